// File: rtl/bcd_display_scan.sv
// bcd_display_scan
// Latches a two-digit BCD value on a load strobe and time-multiplexes it onto
// a common-anode, active-low, two-digit seven-segment display.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens digit (anode
// off, all segments off) whenever the latched tens value is zero.
//
// Timing summary:
//   - load at edge k captures the digits; the glyph reaches seg_n at edge k+1.
//   - The slot select toggles on the edge where the refresh counter wraps.
//   - seg_n and an_n are registered together from the select and digit
//     registers, so they always change on the same edge.

module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg_n,
    output logic [1:0] an_n
);

    // Which digit the scan is currently pointing at.
    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_t;

    // Counter value on which the current slot ends.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Active-low glyphs, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Anode patterns (bit 0 = ones digit, bit 1 = tens digit).
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [CNT_W-1:0] r_cnt;
    slot_t            r_slot;
    logic [6:0]       r_seg_n;
    logic [1:0]       r_an_n;

    logic [CNT_W-1:0] w_cnt_next;
    slot_t            w_slot_next;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_an_next;

    // Decimal digit to active-low segment pattern; non-decimal codes show a dash.
    function automatic logic [6:0] glyph(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // Capture both digits whenever load is high; independent of the scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (load) begin
            r_tens <= tens;
            r_ones <= ones;
        end
    end

    // Scan state register: refresh counter and current slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_slot <= SLOT_ONES;
        end else begin
            r_cnt  <= w_cnt_next;
            r_slot <= w_slot_next;
        end
    end

    // Scan next-state: count up, and on the last count wrap and switch slot.
    always_comb begin
        w_cnt_next  = r_cnt + 1'b1;
        w_slot_next = r_slot;
        if (r_cnt == CNT_LAST) begin
            w_cnt_next  = '0;
            w_slot_next = (r_slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end
    end

    // Output decode from the registered slot and digits (one cycle behind them).
    always_comb begin
        w_seg_next = glyph(r_ones);
        w_an_next  = AN_ONES;
        if (r_slot == SLOT_TENS) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (r_tens == 4'd0) begin
                w_seg_next = SEG_BLANK;
                w_an_next  = AN_OFF;
            end else begin
                w_seg_next = glyph(r_tens);
                w_an_next  = AN_TENS;
            end
`else
            w_seg_next = glyph(r_tens);
            w_an_next  = AN_TENS;
`endif
        end
    end

    // Output register: segments and anodes always move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_n <= SEG_ZERO;
            r_an_n  <= AN_ONES;
        end else begin
            r_seg_n <= w_seg_next;
            r_an_n  <= w_an_next;
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Testbench for bcd_display_scan with REFRESH_DIV = 4.
// A cycle-level model derives the expected display from the number of edges
// since reset and the most recently loaded digits; directed sequences add
// hand-computed expectations for the named scenarios.

module tb_bcd_display_scan;

    localparam int RD = 4;
    localparam int CW = 16;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'h7F;
    localparam logic [7:0] LZ_AN  = 8'h03;
`else
    localparam logic [7:0] LZ_SEG = 8'h40;
    localparam logic [7:0] LZ_AN  = 8'h01;
`endif

    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [7:0] SWEEP_EXP [16] = '{8'h40, 8'h79, 8'h24, 8'h30,
                                              8'h19, 8'h12, 8'h02, 8'h78,
                                              8'h00, 8'h10, 8'h3F, 8'h3F,
                                              8'h3F, 8'h3F, 8'h3F, 8'h3F};

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic [3:0] tens  = 4'd0;
    logic [3:0] ones  = 4'd0;
    logic [6:0] seg_n;
    logic [1:0] an_n;

    int checks = 0;
    int errors = 0;

    bcd_display_scan #(
        .REFRESH_DIV(RD),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .tens (tens),
        .ones (ones),
        .seg_n(seg_n),
        .an_n (an_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h at time %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] model_glyph(input logic [3:0] d);
        return (d < 4'd10) ? GLYPH[d] : 7'h3F;
    endfunction

    // Model: after m edges the selected slot is (m / RD) % 2; the output after
    // edge m+1 shows the slot and digits as they stood after edge m.
    int         m_edges;
    logic [3:0] m_tens, m_ones;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges <= 0;
            m_tens  <= 4'd0;
            m_ones  <= 4'd0;
            exp_seg <= 7'h40;
            exp_an  <= 2'b10;
        end else begin
            m_edges <= m_edges + 1;
            if (load) begin
                m_tens <= tens;
                m_ones <= ones;
            end
            if (((m_edges / RD) % 2) == 1) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (m_tens == 4'd0) begin
                    exp_seg <= 7'h7F;
                    exp_an  <= 2'b11;
                end else
`endif
                begin
                    exp_seg <= model_glyph(m_tens);
                    exp_an  <= 2'b01;
                end
            end else begin
                exp_seg <= model_glyph(m_ones);
                exp_an  <= 2'b10;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_seg", 8'(seg_n), 8'(exp_seg));
        check("model_an", 8'(an_n), 8'(exp_an));
        check("anodes_exclusive", {7'd0, (an_n == 2'b00)}, 8'd0);
    end

    // Advance to the next negedge whose output shows the requested slot.
    task automatic wait_slot(input int slot, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_edges >= 1 && (((m_edges - 1) / RD) % 2) == slot) && n < 4 * RD) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4 * RD) begin
            checks++;
            errors++;
            $display("FAIL %s: slot %0d not reached, required within %0d cycles", name, slot, 4 * RD);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        load = 1'b1;
        tens = t;
        ones = o;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        logic [7:0] e;

        // Reset state and scan timeline after release.
        repeat (2) @(negedge clk);
        check("reset_seg", 8'(seg_n), 8'h40);
        check("reset_an", 8'(an_n), 8'h02);
        reset = 1'b0;
        for (int i = 1; i <= RD + 1; i++) begin
            @(negedge clk);
            e = (i <= RD) ? 8'h02 : LZ_AN;
            $display("timeline edge %0d: an_n=%b seg_n=%h", i, an_n, seg_n);
            check($sformatf("timeline_an_edge%0d", i), 8'(an_n), e);
        end

        // Load 27 and watch both slots and the scan period.
        do_load(4'd2, 4'd7);
        wait_slot(0, "scan_ones");
        $display("load 27 ones slot: an_n=%b seg_n=%h", an_n, seg_n);
        check("scan_ones_seg", 8'(seg_n), 8'h78);
        check("scan_ones_an", 8'(an_n), 8'h02);
        wait_slot(1, "scan_tens");
        $display("load 27 tens slot: an_n=%b seg_n=%h", an_n, seg_n);
        check("scan_tens_seg", 8'(seg_n), 8'h24);
        check("scan_tens_an", 8'(an_n), 8'h01);
        t0 = m_edges;
        wait_slot(0, "period_ones");
        wait_slot(1, "period_tens");
        check("scan_period", 8'(m_edges - t0), 8'd8);

        // Sweep every ones code with tens = 3.
        for (int v = 0; v < 16; v++) begin
            do_load(4'd3, 4'(v));
            wait_slot(0, "sweep_ones");
            $display("sweep ones=%0d: seg_n=%h", v, seg_n);
            check($sformatf("sweep_ones_%0d", v), 8'(seg_n), SWEEP_EXP[v]);
            wait_slot(1, "sweep_tens");
            check($sformatf("sweep_tens_%0d", v), 8'(seg_n), 8'h30);
        end

        // Load on the same edge as the 0 -> 1 slot toggle.
        n = 0;
        while (((m_edges + 1) % (2 * RD)) != RD && n < 4 * RD) begin
            @(negedge clk);
            n++;
        end
        load = 1'b1;
        tens = 4'd1;
        ones = 4'd5;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        $display("collision: an_n=%b seg_n=%h", an_n, seg_n);
        check("collision_seg", 8'(seg_n), 8'h79);
        check("collision_an", 8'(an_n), 8'h01);

        // Tens digit zero.
        do_load(4'd0, 4'd4);
        wait_slot(0, "lz_ones");
        check("lz_ones_seg", 8'(seg_n), 8'h19);
        check("lz_ones_an", 8'(an_n), 8'h02);
        wait_slot(1, "lz_tens");
        $display("tens zero slot: an_n=%b seg_n=%h", an_n, seg_n);
        check("lz_tens_seg", 8'(seg_n), LZ_SEG);
        check("lz_tens_an", 8'(an_n), LZ_AN);

        // Asynchronous reset while the tens slot of 31 is shown.
        do_load(4'd3, 4'd1);
        wait_slot(1, "mid_tens");
        check("mid_tens_seg", 8'(seg_n), 8'h30);
        check("mid_tens_an", 8'(an_n), 8'h01);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset: an_n=%b seg_n=%h", an_n, seg_n);
        check("async_reset_seg", 8'(seg_n), 8'h40);
        check("async_reset_an", 8'(an_n), 8'h02);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_slot(0, "post_reset_ones");
        check("post_reset_ones_seg", 8'(seg_n), 8'h40);
        check("post_reset_ones_an", 8'(an_n), 8'h02);
        check("post_reset_first_edge", 8'(m_edges), 8'd1);
        wait_slot(1, "post_reset_tens");
        check("post_reset_tens_seg", 8'(seg_n), LZ_SEG);
        check("post_reset_tens_an", 8'(an_n), LZ_AN);
        check("post_reset_tens_edge", 8'(m_edges), 8'(RD + 1));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the binary-to-BCD converter stage. Takes its tens digit (t3..t0) and ones digit (o3..o0) as two 4-bit BCD buses.
- Latches both digits on a load strobe.
- Drives a two-digit, common-anode, active-low seven-segment display by time-multiplexing the digits at a parameterised refresh rate.
- Sits between the adder/BCD combinational path and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays active before the scan switches digit. Legal range 1..65535; 0 is illegal.
- CNT_W, 16: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe; when high at a rising clk edge, tens/ones are captured.
- tens  input  4  BCD tens digit from the converter (t3..t0). Values 0..15 accepted.
- ones  input  4  BCD ones digit from the converter (o3..o0). Values 0..15 accepted.
- seg_n  output  7  active-low segments, seg_n[6:0] = g,f,e,d,c,b,a.
- an_n  output  2  active-low digit enables, an_n[0] = ones digit, an_n[1] = tens digit.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high; all state clears immediately on reset assertion, independent of clk.
  - Reset values: tens_q = 0, ones_q = 0, cnt = 0, sel = 0 (ones slot), an_n = 2'b10, seg_n = 7'h40 (glyph '0').
- Capture:
  - load = 1 at edge k: tens_q <= tens and ones_q <= ones at edge k.
  - The new glyph appears on seg_n at edge k+1 if its digit slot is active.
  - load held high recaptures every cycle.
  - load does not disturb cnt or sel.
- Refresh counter:
  - cnt increments each cycle.
  - When cnt == REFRESH_DIV-1: cnt <= 0 and sel <= ~sel on that edge.
  - REFRESH_DIV = 1: sel toggles every cycle.
- Output stage (registered, one cycle after sel and digit registers):
  - sel = 0: an_n <= 2'b10, seg_n <= glyph(ones_q).
  - sel = 1: an_n <= 2'b01, seg_n <= glyph(tens_q).
  - an_n and seg_n always update on the same edge. Both anodes are never low together.
- Glyph table (hex, active-low, bit6 = g): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
- Invalid BCD (10..15): 3F (centre dash, segment g only).
- Simultaneous events: load at the same edge as a sel toggle is legal. The output at the next edge uses the new sel and the new digit values.
- Reset mid-scan: outputs return to the reset values asynchronously. Scanning restarts from the ones slot with cnt = 0 after reset deasserts.
- Scan timeline from reset release:
  - Edges 1..3: cnt = 1..3.
  - Edge REFRESH_DIV: sel = 1.
  - Edge REFRESH_DIV+1: outputs show the tens slot.
  - Scan period = 2*REFRESH_DIV cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when sel = 1 and tens_q == 0, the output stage drives seg_n = 7'h7F and an_n = 2'b11 (tens digit dark). The ones slot is unaffected, so value 0 shows a single '0'.
- Undefined: the tens slot always displays glyph(tens_q), including '0' (seg_n = 40, an_n = 01).

Test Plan:
- Reset check: assert reset mid-cycle with REFRESH_DIV = 4 -> seg_n = 40 and an_n = 10 immediately, before any clk edge; after release, cnt counts 1,2,3 and sel = 1 at edge 4.
- Load and scan: REFRESH_DIV = 4, load tens = 2, ones = 7 for one cycle -> ones slot seg_n = 78 / an_n = 10; after the toggle, tens slot seg_n = 24 / an_n = 01; pattern repeats every 8 cycles.
- Full digit sweep: load each ones value 0..15 with tens = 3 -> seg_n matches the glyph table for 0..9 and shows 3F for 10..15; tens slot always shows 30.
- Collision: assert load (tens = 1, ones = 5) on the same edge sel toggles 0->1 -> next edge seg_n = 79, an_n = 01, no stale glyph.
- Leading-zero blanking: load tens = 0, ones = 4. Macro defined -> tens slot seg_n = 7F, an_n = 11. Macro undefined -> seg_n = 40, an_n = 01. Ones slot is 19 in both builds.
- Mid-operation reset: reset asserted while sel = 1 with 31 loaded (tens = 3, ones = 1) -> an_n = 10, seg_n = 40 immediately; after release the display shows '00' until the next load.
